fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32, word-aligned byte address of the request.
REQ-006 SHALL have port imem_ack, input, 1, read data valid; meaningful only while imem_req=1.
REQ-007 SHALL have port imem_rdata, input, 32, instruction word returned with imem_ack.
REQ-008 SHALL have port redirect_valid, input, 1, branch/jump taken; load redirect_pc.
REQ-009 SHALL have port redirect_pc, input, 32, target address.
REQ-010 SHALL have port IR, output, 32, instruction presented to decode_unit.
REQ-011 SHALL have port PC, output, 32, address of the instruction in IR.
REQ-012 SHALL have port ir_valid, output, 1, IR/PC hold a valid instruction.
REQ-013 SHALL have port ir_ready, input, 1, decode accepts IR; transfer when ir_valid&ir_ready.
REQ-014 SHALL have port fetch_err, output, 1, misaligned-target error (present only under FETCH_ALIGN_CHK_EN; tied 0 otherwise).

Function
REQ-015 SHALL implement FSM states S_REQ, S_HOLD, S_ERR; imem_req = (state==S_REQ) & ~rst.
REQ-016 SHALL drive imem_addr = internal pc, stable for every cycle imem_req=1 absent redirect.
REQ-017 In S_REQ with imem_ack=1: IR<=imem_rdata, PC<=pc, ir_valid<=1, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), go S_HOLD.
REQ-018 In S_REQ with imem_ack=0: hold all state; wait indefinitely.
REQ-019 In S_HOLD: IR, PC, ir_valid=1 held stable until ir_ready=1; then ir_valid<=0, go S_REQ.
REQ-020 Throughput SHALL be at most one instruction per two cycles; ack-to-ir_valid latency one cycle.
REQ-021 redirect_valid=1 SHALL take priority in every state except S_ERR: pc<=redirect_pc, ir_valid<=0, go S_REQ; a coincident imem_ack is discarded; a coincident ir_ready handshake still completes (instruction counted as consumed).
REQ-022 IR and PC SHALL retain last value when ir_valid=0.
REQ-023 S_ERR SHALL be exited only by rst.

Reset
REQ-024 On rst=1 at a clock edge: pc<=RESET_PC, IR<=0, PC<=0, ir_valid<=0, fetch_err<=0, state<=S_REQ.
REQ-025 While rst=1, imem_req SHALL be 0; first request issues in the cycle after rst deasserts.
REQ-026 rst mid-transaction SHALL abandon the outstanding request; any ack during rst is ignored.

Configuration
REQ-027 With FETCH_ALIGN_CHK_EN defined: redirect_valid with redirect_pc[1:0]!=0 SHALL go S_ERR, set fetch_err<=1, ir_valid<=0, imem_req=0; fetch_err sticky until rst.
REQ-028 Without FETCH_ALIGN_CHK_EN: redirect_pc[1:0] forced to 0 when loaded; fetch_err tied 0; S_ERR unreachable.

Structure
REQ-029 Shared package riscv_pkg SHALL hold INSTR_BYTES=4, fetch state encodings, and opcode constants (I/L/S/B/J) shared with decode_unit.
REQ-030 Sub-module pc_gen SHALL own the pc register and next-PC mux (reset, +4, redirect, hold).

Verification
REQ-031 Reset with RESET_PC=32'h100; release -> next cycle imem_req=1, imem_addr=32'h100; ir_valid=0, IR=0.
REQ-032 Ack at 0x100 with rdata 32'h00500093, ir_ready=1 -> IR=32'h00500093, PC=0x100, ir_valid one cycle, then imem_addr=0x104.
REQ-033 ir_ready=0 for 5 cycles -> IR/PC/ir_valid stable, imem_req=0; ready=1 -> next request 0x104.
REQ-034 redirect_valid with redirect_pc=32'h200 in same cycle as imem_ack -> ack data dropped, ir_valid=0, next imem_addr=0x200.
REQ-035 pc=32'hFFFF_FFFC, ack -> PC=32'hFFFF_FFFC, next imem_addr=0.
REQ-036 FETCH_ALIGN_CHK_EN, redirect_pc=32'h202 -> fetch_err=1, imem_req=0 until rst; without macro -> imem_addr=0x200.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: instruction size, fetch FSM encoding
// and the major opcodes that fetch_unit and decode_unit agree on.
package riscv_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] INSTR_STEP       = 32'(INSTR_BYTES);
    localparam logic [31:0] INSTR_ALIGN_MASK = 32'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_ERR  = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;  // I-type ALU
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;  // L-type
    localparam logic [6:0] OPC_STORE  = 7'b0100011;  // S-type
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;  // B-type
    localparam logic [6:0] OPC_JAL    = 7'b1101111;  // J-type

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr & INSTR_ALIGN_MASK) == 32'd0;
    endfunction

endpackage

// File: rtl/pc_gen.sv
// Fetch program counter: owns the pc register and its next-value mux
// (reset, redirect, sequential +4, hold). Loaded targets are forced word-aligned.
module pc_gen
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    input  logic        inc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        // NOTE: default assignment first so no path leaves pc_d unassigned (no latch).
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i & ~INSTR_ALIGN_MASK;
        end else if (inc_i) begin
            pc_d = pc_q + INSTR_STEP;
        end
    end

    // NOTE: non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one word at pc, holds it in IR/PC until
// decode accepts it. Define FETCH_ALIGN_CHK_EN to trap misaligned redirects.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] IR,
    output logic [31:0] PC,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        fetch_err
);

    fetch_state_e state_q;
    logic [31:0]  ir_q;
    logic [31:0]  pc_out_q;
    logic         ir_valid_q;
    logic [31:0]  pc;
    logic         pc_load;
    logic         pc_inc;

    // A redirect wins over a coincident ack, so the ack only advances pc alone.
    assign pc_load = redirect_valid & (state_q != S_ERR);
    assign pc_inc  = (state_q == S_REQ) & imem_ack & ~redirect_valid;

    pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (pc_load),
        .load_pc_i (redirect_pc),
        .inc_i     (pc_inc),
        .pc_o      (pc)
    );

`ifdef FETCH_ALIGN_CHK_EN
    logic fetch_err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            ir_q       <= 32'd0;
            pc_out_q   <= 32'd0;
            ir_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            fetch_err_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_REQ, S_HOLD: begin
                    if (redirect_valid) begin
                        ir_valid_q <= 1'b0;
                        state_q    <= S_REQ;
`ifdef FETCH_ALIGN_CHK_EN
                        if (!is_aligned(redirect_pc)) begin
                            state_q     <= S_ERR;
                            fetch_err_q <= 1'b1;
                        end
`endif
                    end else if (state_q == S_REQ) begin
                        if (imem_ack) begin
                            ir_q       <= imem_rdata;
                            pc_out_q   <= pc;
                            ir_valid_q <= 1'b1;
                            state_q    <= S_HOLD;
                        end
                    end else if (ir_ready) begin
                        ir_valid_q <= 1'b0;
                        state_q    <= S_REQ;
                    end
                end
                default: ;  // S_ERR is left only through rst
            endcase
        end
    end

    assign imem_req  = (state_q == S_REQ) & ~rst;
    assign imem_addr = pc;
    assign IR        = ir_q;
    assign PC        = pc_out_q;
    assign ir_valid  = ir_valid_q;

`ifdef FETCH_ALIGN_CHK_EN
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed boundary cases followed by a
// randomized run checked against a scoreboard of expected {IR, PC} pairs.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } fetch_rec_t;

    fetch_rec_t sb_q[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .IR             (ir),
        .PC             (pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .fetch_err      (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        exp_valid;
        logic        was_valid;
        fetch_rec_t  rec;

        rst            = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        ir_ready       = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);

        rst = 1'b0;
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RESET_PC);

        // Single fetch accepted immediately
        imem_ack   = 1'b1;
        imem_rdata = 32'h0050_0093;
        ir_ready   = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("f1_valid", 32'(ir_valid), 32'd1);
        check("f1_ir", ir, 32'h0050_0093);
        check("f1_pc", pc, 32'h0000_0100);
        check("f1_req", 32'(imem_req), 32'd0);
        tick();
        check("f1_valid_drop", 32'(ir_valid), 32'd0);
        check("f1_next_addr", imem_addr, 32'h0000_0104);
        check("f1_next_req", 32'(imem_req), 32'd1);
        check("f1_ir_retained", ir, 32'h0050_0093);

        // Decode back-pressure for five cycles
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A0_0113;
        ir_ready   = 1'b0;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(ir_valid), 32'd1);
            check("stall_ir", ir, 32'h00A0_0113);
            check("stall_pc", pc, 32'h0000_0104);
            check("stall_req", 32'(imem_req), 32'd0);
            tick();
        end
        ir_ready = 1'b1;
        tick();
        check("stall_release_valid", 32'(ir_valid), 32'd0);
        check("stall_release_addr", imem_addr, 32'h0000_0108);

        // Redirect coincident with ack drops the ack data
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        imem_ack       = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        tick();
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        check("redir_ack_valid", 32'(ir_valid), 32'd0);
        check("redir_ack_addr", imem_addr, 32'h0000_0200);
        check("redir_ack_ir", ir, 32'h00A0_0113);

        // Redirect while holding an unaccepted instruction
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        ir_ready   = 1'b0;
        tick();
        imem_ack       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        check("redir_hold_valid", 32'(ir_valid), 32'd0);
        check("redir_hold_addr", imem_addr, 32'h0000_0300);
        check("redir_hold_ir", ir, 32'h1234_5678);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_006F;
        ir_ready   = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_next_addr", imem_addr, 32'h0000_0000);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        check("mis_err", 32'(fetch_err), 32'd1);
        check("mis_req", 32'(imem_req), 32'd0);
        check("mis_valid", 32'(ir_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        imem_ack       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_sticky", 32'(fetch_err), 32'd1);
            check("err_no_req", 32'(imem_req), 32'd0);
        end
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
`else
        check("mis_addr", imem_addr, 32'h0000_0200);
        check("mis_err", 32'(fetch_err), 32'd0);
        check("mis_req", 32'(imem_req), 32'd1);
`endif

        // Reset mid-transaction with an ack that must be ignored
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0BAD_0BAD;
        tick();
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_valid", 32'(ir_valid), 32'd0);
        tick();
        rst      = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("midrst_addr", imem_addr, RESET_PC);
        check("midrst_ir", ir, 32'd0);
        check("midrst_err", 32'(fetch_err), 32'd0);

        // Randomized traffic against the scoreboard
        exp_pc    = RESET_PC;
        exp_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            check("rnd_req", 32'(imem_req), 32'(!exp_valid));
            check("rnd_valid", 32'(ir_valid), 32'(exp_valid));
            if (!exp_valid) check("rnd_addr", imem_addr, exp_pc);

            ir_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            tgt            = $urandom() & 32'hFFFF_FFFC;
            redirect_pc    = tgt;
            imem_ack       = imem_req && ($urandom_range(0, 1) == 1);
            imem_rdata     = mem_word(imem_addr);

            was_valid = exp_valid;
            if (exp_valid && ir_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    rec = sb_q.pop_front();
                    check("sb_ir", ir, rec.ir);
                    check("sb_pc", pc, rec.pc);
                end
                exp_valid = 1'b0;
            end else if (exp_valid && redirect_valid) begin
                if (sb_q.size() != 0) void'(sb_q.pop_front());
                exp_valid = 1'b0;
            end
            if (redirect_valid) begin
                exp_pc = tgt;
            end else if (!was_valid && imem_ack) begin
                sb_q.push_back('{ir: mem_word(exp_pc), pc: exp_pc});
                exp_pc    = exp_pc + 32'd4;
                exp_valid = 1'b1;
            end
            tick();
        end
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        check("sb_depth", 32'(sb_q.size()), 32'(exp_valid));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
